// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder: 2^ADDR_WIDTH byte RAM plus a memory-mapped
// UART window (TX/RX byte FIFOs, status register and a sticky halt flag).
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(FIFO_DEPTH - 1);
  localparam logic [17:0]   IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0]   IO_CTRL_ADDR = 18'h30004;

  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count, tx_count_nxt, rx_count_nxt;

  logic [17:0] dec_a_p0;
  logic        acc_en_p0, io_sel_p0;
  logic        ram_wr_p0, tx_wr_p0, halt_wr_p0, rx_rd_p0;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]  rd_data_p0;
  logic        unused_hi;

  assign unused_hi = ^mem_a[31:18];

  // Stage p0: address decode; nothing is written while reset is held
  assign dec_a_p0   = mem_a[17:0];
  assign acc_en_p0  = !rst_in;
  assign io_sel_p0  = (dec_a_p0[17:16] == 2'b11);
  assign ram_wr_p0  = acc_en_p0 && mem_wr && !io_sel_p0;
  assign tx_wr_p0   = acc_en_p0 && mem_wr && (dec_a_p0 == IO_DATA_ADDR);
  assign halt_wr_p0 = acc_en_p0 && mem_wr && (dec_a_p0 == IO_CTRL_ADDR);
  assign rx_rd_p0   = acc_en_p0 && !mem_wr && (dec_a_p0 == IO_DATA_ADDR);

  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign rx_ready = (rx_count != DEPTH_C);

  // A full TX FIFO still accepts a byte when its head leaves in the same cycle
  assign tx_pop  = tx_valid && tx_ready;
  assign tx_push = tx_wr_p0 && ((tx_count != DEPTH_C) || tx_pop);
  assign rx_push = acc_en_p0 && rx_valid && rx_ready;
  assign rx_pop  = rx_rd_p0 && (rx_count != '0);

  assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);

  always_comb begin
    rd_data_p0 = 8'h00;
    if (!io_sel_p0) begin
      rd_data_p0 = ram[mem_a[ADDR_WIDTH-1:0]];
    end else if (dec_a_p0 == IO_DATA_ADDR) begin
      if (rx_count != '0) rd_data_p0 = rx_mem[rx_rd_ptr];
    end else if (dec_a_p0 == IO_CTRL_ADDR) begin
      rd_data_p0 = {6'b0, (rx_count != '0), (tx_count == DEPTH_C)};
    end
  end

  // Stage p1: storage arrays, no reset so RAM survives it
  always_ff @(posedge clk_in) begin
    if (ram_wr_p0) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    if (tx_push)   tx_mem[tx_wr_ptr] <= mem_dout;
    if (rx_push)   rx_mem[rx_wr_ptr] <= rx_data;
  end

  // Stage p1: registered read data, FIFO bookkeeping and status flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      sim_halt       <= 1'b0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      rx_count       <= '0;
    end else begin
      if (!mem_wr)    mem_din   <= rd_data_p0;
      if (halt_wr_p0) sim_halt  <= 1'b1;
      if (tx_push)    tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push)    rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + 1'b1;
      tx_count       <= tx_count_nxt;
      rx_count       <= rx_count_nxt;
      io_buffer_full <= (tx_count_nxt >= NEAR_FULL_C);
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized and directed bench for mem_io_responder, checked every cycle
// against a queue-based behavioural model of RAM, FIFOs and halt flag.
module tb_mem_io_responder;

  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sim_halt;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_m [logic [16:0]];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] dut_emit [$];
  logic [7:0] exp_din;
  bit         din_vld;
  bit         exp_halt;

  mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .sim_halt(sim_halt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    exp_halt = 1'b0;
    exp_din  = 8'h00;
    din_vld  = 1'b1;
  endtask

  // One clock of the behavioural model, using the inputs present at the edge
  task automatic model_tick();
    logic [17:0] a;
    logic [7:0]  rd;
    bit io, tpop, tpush, rpop, rpush;
    if (rst_in) begin
      model_reset();
      return;
    end
    a     = mem_a[17:0];
    io    = (a[17:16] == 2'b11);
    tpop  = (tx_q.size() != 0) && tx_ready;
    rpush = rx_valid && (rx_q.size() != DEPTH);
    tpush = 1'b0;
    rpop  = 1'b0;
    if (!mem_wr) begin
      din_vld = 1'b1;
      rd = 8'h00;
      if (!io) begin
        if (ram_m.exists(a[16:0])) rd = ram_m[a[16:0]];
        else din_vld = 1'b0;
      end else if (a == 18'h30000) begin
        if (rx_q.size() != 0) begin
          rd = rx_q[0];
          rpop = 1'b1;
        end
      end else if (a == 18'h30004) begin
        rd = {6'b0, rx_q.size() != 0, tx_q.size() == DEPTH};
      end
      exp_din = rd;
    end else begin
      din_vld = 1'b0;
      if (!io) ram_m[a[16:0]] = mem_dout;
      else if (a == 18'h30000) tpush = (tx_q.size() < DEPTH) || tpop;
      else if (a == 18'h30004) exp_halt = 1'b1;
    end
    if (tpop)  void'(tx_q.pop_front());
    if (tpush) tx_q.push_back(mem_dout);
    if (rpop)  void'(rx_q.pop_front());
    if (rpush) rx_q.push_back(rx_data);
  endtask

  task automatic compare();
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    chk("io_buffer_full", io_buffer_full, tx_q.size() >= DEPTH - 1);
    chk("rx_ready", rx_ready, rx_q.size() != DEPTH);
    chk("sim_halt", sim_halt, exp_halt);
    if (din_vld) chk("mem_din", mem_din, exp_din);
  endtask

  task automatic step();
    if (tx_valid && tx_ready) dut_emit.push_back(tx_data);
    @(posedge clk_in);
    model_tick();
    #1;
    compare();
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
  endtask

  logic [7:0] seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] rx_exp [4] = '{8'h02, 8'hA0, 8'hA1, 8'h00};
  logic [31:0] rx_addr [4] = '{32'h30004, 32'h30000, 32'h30000, 32'h30000};

  initial begin
    rst_in = 1'b1;
    drive(32'h0, 1'b0, 8'h00);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    step();
    step();
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_io_buffer_full", io_buffer_full, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_sim_halt", sim_halt, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    rst_in = 1'b0;

    // sequential writes then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + i, 1'b1, seq[i]);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + i, 1'b0, 8'h00);
      step();
      chk("ram_seq_read", mem_din, seq[i]);
    end
    drive(32'h200, 1'b1, 8'h5A);
    step();
    drive(32'h200, 1'b0, 8'h00);
    step();
    chk("read_after_write", mem_din, 8'h5A);

    // fill TX FIFO with the UART stalled, ninth byte must be dropped
    for (int i = 1; i <= 9; i++) begin
      drive(32'h30000, 1'b1, 8'h41);
      step();
      if (i == 6) chk("near_full_after_6", io_buffer_full, 1'b0);
      if (i == 7) chk("near_full_after_7", io_buffer_full, 1'b1);
    end
    drive(32'h100, 1'b0, 8'h00);
    tx_ready = 1'b1;
    dut_emit.delete();
    repeat (12) step();
    chk("tx_drain_count", dut_emit.size(), 8);
    foreach (dut_emit[i]) chk("tx_drain_byte", dut_emit[i], 8'h41);
    chk("tx_empty_after_drain", tx_valid, 1'b0);

    // push into a full FIFO while its head pops
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(32'h30000, 1'b1, 8'h50 + 8'(i));
      step();
    end
    tx_ready = 1'b1;
    drive(32'h30000, 1'b1, 8'h99);
    dut_emit.delete();
    step();
    chk("full_push_pop_near_full", io_buffer_full, 1'b1);
    drive(32'h100, 1'b0, 8'h00);
    repeat (12) step();
    chk("full_push_pop_count", dut_emit.size(), 9);
    if (dut_emit.size() == 9) begin
      chk("full_push_pop_first", dut_emit[0], 8'h50);
      chk("full_push_pop_last", dut_emit[8], 8'h99);
    end

    // RX bytes then status and data reads
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA0;
    step();
    rx_data  = 8'hA1;
    step();
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(rx_addr[i], 1'b0, 8'h00);
      step();
      chk("rx_read_seq", mem_din, rx_exp[i]);
    end

    // sticky halt, cleared immediately by reset
    drive(32'h30004, 1'b1, 8'h77);
    step();
    chk("halt_set", sim_halt, 1'b1);
    drive(32'h100, 1'b0, 8'h00);
    repeat (3) step();
    chk("halt_hold", sim_halt, 1'b1);
    rst_in = 1'b1;
    #1;
    chk("halt_async_clear", sim_halt, 1'b0);
    model_reset();
    compare();
    step();
    rst_in = 1'b0;

    // reset between read issue and data cycle; a write under reset is ignored
    drive(32'h101, 1'b0, 8'h00);
    step();
    drive(32'h102, 1'b0, 8'h00);
    #2;
    rst_in = 1'b1;
    #1;
    chk("rst_mid_read_async", mem_din, 8'h00);
    model_reset();
    drive(32'h100, 1'b1, 8'hEE);
    step();
    chk("rst_mid_read_data", mem_din, 8'h00);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + i, 1'b0, 8'h00);
      step();
      chk("ram_kept_after_rst", mem_din, seq[i]);
    end

    // randomized traffic with shifting TX/RX pressure
    for (int n = 0; n < 3000; n++) begin
      logic [17:0] a18;
      case ($urandom_range(0, 5))
        0, 1, 2: a18 = 18'h01000 + 18'($urandom_range(0, 63));
        3:       a18 = 18'h30000;
        4:       a18 = ($urandom_range(0, 7) == 0) ? 18'h30004 : 18'h30000;
        default: a18 = 18'h30008;
      endcase
      mem_a    = {14'($urandom), a18};
      mem_wr   = $urandom_range(0, 1) == 1;
      mem_dout = 8'($urandom);
      if (n < 1500) begin
        tx_ready = $urandom_range(0, 3) == 0;
        rx_valid = $urandom_range(0, 3) != 0;
      end else begin
        tx_ready = $urandom_range(0, 3) != 0;
        rx_valid = $urandom_range(0, 3) == 0;
      end
      rx_data = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the RAM byte-address width (2^17 bytes).
REQ-002 Parameter FIFO_DEPTH, default 8 (power of two), SHALL set the depth of the TX FIFO and of the RX FIFO.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  reset.
REQ-006 mem_a  input  32  byte address from the initiator; only bits 17:0 are decoded.
REQ-007 mem_wr  input  1  1 = write, 0 = read, sampled every cycle.
REQ-008 mem_dout  input  8  write data from the initiator.
REQ-009 mem_din  output  8  read data to the initiator.
REQ-010 io_buffer_full  output  1  TX FIFO near-full indication.
REQ-011 tx_valid / tx_data / tx_ready  output 1 / output 8 / input 1  TX byte stream to the UART.
REQ-012 rx_valid / rx_data / rx_ready  input 1 / input 8 / output 1  RX byte stream from the UART.
REQ-013 sim_halt  output  1  sticky program-end flag.

Function
REQ-014 The block SHALL decode an IO access when mem_a[17:16]==2'b11 and a RAM access otherwise.
REQ-015 RAM write: when mem_wr=1 in cycle N, ram[mem_a[ADDR_WIDTH-1:0]] SHALL be updated at the end of cycle N with mem_dout.
REQ-016 RAM read: when mem_wr=0 in cycle N, mem_din SHALL be driven with ram[addr] during cycle N+1.
REQ-017 Read latency SHALL be exactly one cycle for back-to-back sequential reads, and a new address is accepted every cycle.
REQ-018 A read in cycle N+1 of an address written in cycle N SHALL return the new data.
REQ-019 IO write to 0x30000 SHALL push mem_dout into the TX FIFO if it is not full.
REQ-020 IO write to 0x30000 when the TX FIFO is full SHALL drop the byte and leave FIFO contents unchanged.
REQ-021 IO write to 0x30004 SHALL set sim_halt to 1, and sim_halt SHALL stay 1 until reset.
REQ-022 IO read of 0x30000 SHALL return the RX FIFO head in cycle N+1 and pop it; if the RX FIFO is empty it SHALL return 8'h00 and not pop.
REQ-023 IO read of 0x30004 SHALL return {6'b0, rx_nonempty, tx_full} in cycle N+1.
REQ-024 IO reads of other addresses SHALL return 8'h00, and IO writes to other addresses SHALL have no effect.
REQ-025 IO reads are registered exactly like RAM reads, so mem_din is a single registered output.
REQ-026 io_buffer_full SHALL be a registered output equal to (tx_count >= FIFO_DEPTH-1), giving one slot of margin for a write issued in the same cycle.
REQ-027 TX handshake:
- tx_valid SHALL equal (tx_count != 0) and tx_data SHALL equal the TX FIFO head.
- The head SHALL pop on tx_valid && tx_ready.
REQ-028 RX handshake:
- rx_ready SHALL equal (rx_count != FIFO_DEPTH).
- rx_data SHALL be pushed on rx_valid && rx_ready.
REQ-029 On a simultaneous push and pop of the same FIFO, the count SHALL remain unchanged and both operations SHALL take effect.
REQ-030 A pop of a full FIFO in the same cycle as a push SHALL be legal, whereas a push while full without a pop SHALL be dropped.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and counts SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-032 Data order SHALL be FIFO, with no byte loss or duplication across pointer wrap.

Reset
REQ-033 On rst_in=1, asynchronously:
- mem_din=0, io_buffer_full=0, tx_valid=0, sim_halt=0;
- rx_ready=1;
- both FIFOs emptied (pointers and counts 0).
REQ-034 RAM contents SHALL NOT be affected by reset.
REQ-035 Reset asserted mid-transfer SHALL discard any pending read data and FIFO contents, and no write SHALL occur in a cycle where rst_in=1.

Verification
REQ-036 Write 0x12,0x34,0x56,0x78 to 0x100..0x103, then read 0x100..0x103 on consecutive cycles -> mem_din=0x12,0x34,0x56,0x78 in cycles N+1..N+4.
REQ-037 With tx_ready=0, write 0x41 to 0x30000 eight times -> io_buffer_full=1 after the 7th push; tx_count=8; a 9th write is dropped; raising tx_ready yields exactly 8 bytes of 0x41.
REQ-038 Drive rx bytes 0xA0,0xA1, then read 0x30004, 0x30000, 0x30000, 0x30000 -> mem_din=0x02, then 0xA0, 0xA1, 0x00.
REQ-039 With the TX FIFO full and tx_ready=1, issue a write to 0x30000 in the same cycle -> tx_count stays 8 and the new byte is emitted last.
REQ-040 Write any value to 0x30004 -> sim_halt=1 the next cycle and it holds; assert rst_in -> sim_halt=0 immediately.
REQ-041 Assert rst_in between a read issue and its data cycle -> mem_din=0; previously written RAM bytes still read back correctly after reset.
